ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
Synthesizable AHB3-Lite slave with an internal word-addressed memory array, programmable wait states and protocol-correct two-cycle ERROR responses. It is the responder end for the interconnect bench's AHB3-Lite driver: it attaches to an interconnect slave port and gives the bench and scoreboard a real, timing-accurate target. Every transfer the interconnect routes to it completes, with OKAY or ERROR, within a bounded number of cycles.

Parameters:
HADDR_SIZE, 32, address width
HDATA_SIZE, 32, data width; one of 32 or 64
MEM_DEPTH, 256, number of HDATA_SIZE-bit words; valid byte range 0 .. MEM_DEPTH*HDATA_SIZE/8-1
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous, active-high reset
HSEL  in  1  slave select
HADDR  in  HADDR_SIZE  transfer address
HWDATA  in  HDATA_SIZE  write data; valid in data phase
HRDATA  out  HDATA_SIZE  read data
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size
HBURST  in  3  burst type; ignored, each beat handled independently
HPROT  in  4  protection; ignored
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-wide ready
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset, asynchronous while HRESET=1: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending write cleared. Memory contents are not reset.
- Reset asserted mid-transfer aborts the transfer. A write whose data phase has not completed is not committed.
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, register HADDR, HWRITE and HSIZE; the next cycle is the data phase.
- IDLE or BUSY with HSEL & HREADY: zero-wait OKAY; no memory access.
- Error check at accept. Any of the following gives ERROR:
  - address out of range;
  - 8 << HSIZE > HDATA_SIZE;
  - address not aligned to the size.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE -> ERR1 on an erroring accept.
  - ERR1: HREADYOUT=0, HRESP=1, one cycle.
  - ERR2: HREADYOUT=1, HRESP=1, one cycle.
  - ERR2 -> IDLE, or may accept a new transfer in the same cycle.
- IDLE -> WAIT on an OKAY accept when WAIT_STATES>0.
  - Counter loads WAIT_STATES-1.
  - HREADYOUT=0, HRESP=0 while in WAIT.
  - Leave WAIT when the counter reaches 0; the final cycle has HREADYOUT=1.
  - Data phase length is WAIT_STATES+1 cycles.
- With WAIT_STATES=0 the data phase completes in one cycle with HREADYOUT=1, allowing back-to-back pipelined transfers.
- Reads: HRDATA returns mem[registered word address] for the full data word, all lanes, valid in the last data-phase cycle (HREADYOUT=1). HRDATA holds its value outside read data phases.
- Writes: HWDATA is sampled in the last data-phase cycle and committed at that edge.
  - Byte enables are little-endian, derived from the registered HSIZE and low address bits.
  - Only enabled lanes change.
- Read-after-write forwarding: a read whose address phase coincides with the preceding write's data phase must return the merged new data. No stale read is allowed.
- Not-ready cycles: HSEL/HTRANS sampled while HREADY=0 are ignored, since another slave is stalling.
- ERROR transfers never modify memory. HRDATA is unchanged on an erroring read.

Test Plan:
- Reset, WAIT_STATES=0: HRESET pulse -> HREADYOUT=1, HRESP=0, HRDATA=0. Write NONSEQ word 0xDEADBEEF to 0x10, then read 0x10 -> read returns 0xDEADBEEF with zero waits.
- Byte lanes: word 0x11223344 at 0x20; byte write 0xAA at 0x21; halfword write 0x5566 at 0x22 -> read 0x20 returns 0x5566AA44.
- WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then high with data. Burst of 4 SEQ reads -> 16 data-phase cycles total.
- Errors, MEM_DEPTH=256, 32-bit: read 0x400 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). Halfword at 0x3 -> ERROR. Memory unchanged afterwards.
- Pipelined RAW, WAIT_STATES=0: write 0x0000CAFE at 0x40 immediately followed by read 0x40 -> read returns 0x0000CAFE. IDLE/BUSY cycles interleaved -> OKAY, zero wait.
- Reset mid-write: with WAIT_STATES=2, assert HRESET during the write data phase to 0x50 -> after reset, read 0x50 returns the prior value; outputs return to their reset values immediately.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
// -----------------------------------------------------------------------------
// ahb3lite_sram_slave
//
// AHB3-Lite slave backed by an internal word-addressed memory. Each accepted
// transfer gets an OKAY data phase stretched by WAIT_STATES not-ready cycles,
// or a two-cycle ERROR response when the address is out of range, the size is
// wider than the data bus, or the address is not aligned to the size. Bursts
// are treated as a sequence of independent beats.
//
// Ports:
//   HCLK       clock
//   HRESET     asynchronous, active-high reset
//   HSEL       slave select
//   HADDR      transfer address (address phase)
//   HWDATA     write data (data phase)
//   HRDATA     read data, valid in the last data-phase cycle, held otherwise
//   HWRITE     1 = write, 0 = read
//   HSIZE      transfer size, bytes = 1 << HSIZE
//   HBURST     burst type (unused)
//   HPROT      protection attributes (unused)
//   HTRANS     IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   HMASTLOCK  locked transfer (unused)
//   HREADY     bus-wide ready; an address phase is only taken when high
//   HREADYOUT  this slave's ready
//   HRESP      0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES     = HDATA_SIZE / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int AW        = OFF_W + IDX_W;
    localparam int MEM_BYTES = MEM_DEPTH * BYTES;

    // IDLE also hosts the final (ready) cycle of an OKAY data phase.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_dp;        // an OKAY data phase is in progress
    logic                  r_write;
    logic [2:0]            r_size;
    logic [AW-1:0]         r_addr;
    logic [HDATA_SIZE-1:0] r_hrdata;
    logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_err_range;
    logic                  w_err_size;
    logic                  w_err_align;
    logic                  w_err;
    logic                  w_ok_accept;
    logic                  w_err_accept;
    logic [2:0]            w_align_mask;
    logic [OFF_W-1:0]      w_off;
    logic [BYTES-1:0]      w_be;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_commit;
    logic                  w_rd_load;
    logic [HDATA_SIZE-1:0] w_rd_word;

    // Attributes this slave deliberately ignores.
    logic w_unused;
    assign w_unused = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // ------------------------------------------------------------------
    // Outputs decode straight from the state register.
    // ------------------------------------------------------------------
    assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign HRDATA    = r_hrdata;

    // ------------------------------------------------------------------
    // Address-phase decode. HREADYOUT is included so a mis-wired HREADY
    // can never start a transfer while we are still mid data phase.
    // ------------------------------------------------------------------
    assign w_accept     = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign w_err_range  = HADDR >= HADDR_SIZE'(MEM_BYTES);
    assign w_err_size   = HSIZE > 3'(OFF_W);
    // Low-bit mask for the size; HSIZE=3 wraps to 3'b111 which is the
    // doubleword mask, larger sizes are rejected by w_err_size anyway.
    assign w_align_mask = (3'b001 << HSIZE) - 3'b001;
    assign w_err_align  = |(HADDR[2:0] & w_align_mask);
    assign w_err        = w_err_range | w_err_size | w_err_align;
    assign w_ok_accept  = w_accept & ~w_err;
    assign w_err_accept = w_accept & w_err;

    // ------------------------------------------------------------------
    // Data-phase lanes, from the registered size and address.
    // ------------------------------------------------------------------
    assign w_off    = r_addr[OFF_W-1:0];
    assign w_wr_idx = r_addr[OFF_W +: IDX_W];

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise synthesis infers a latch for the untouched paths.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + (1 << int'(r_size)));
        end
    end

    // A write commits at the end of its last (ready) data-phase cycle.
    assign w_commit = r_dp & r_write & (r_state == ST_IDLE);

    // HRDATA is loaded on the edge that opens the last data-phase cycle.
    // Without wait states that edge is the accept itself, so the word
    // index comes straight from HADDR; otherwise from the registered address.
    assign w_rd_load = (WAIT_STATES == 0)
                     ? (w_ok_accept & ~HWRITE)
                     : ((r_state == ST_WAIT) && (r_cnt == 4'd0) && r_dp && !r_write);
    assign w_rd_idx  = (WAIT_STATES == 0) ? HADDR[OFF_W +: IDX_W] : w_wr_idx;

    // Forwarding: a write committing on the same edge as the read load is
    // merged in lane by lane so a back-to-back read never sees stale data.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int b = 0; b < BYTES; b++) begin
            if (w_commit && (w_wr_idx == w_rd_idx) && w_be[b]) begin
                w_rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered transfer attributes.
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_dp     <= 1'b0;
            r_write  <= 1'b0;
            r_size   <= 3'd0;
            r_addr   <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_rd_load) begin
                r_hrdata <= w_rd_word;
            end

            case (r_state)
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_ERR1: begin
                    r_state <= ST_ERR2;
                end

                default: begin
                    // IDLE or ERR2: a ready cycle that ends any data phase
                    // and may take the next address phase.
                    r_dp    <= 1'b0;
                    r_state <= ST_IDLE;
                    if (w_err_accept) begin
                        r_state <= ST_ERR1;
                    end else if (w_ok_accept) begin
                        r_dp    <= 1'b1;
                        r_write <= HWRITE;
                        r_size  <= HSIZE;
                        r_addr  <= HADDR[AW-1:0];
                        if (WAIT_STATES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. Reset aborts a pending write because it clears r_dp.
    // ------------------------------------------------------------------
    // NOTE: the memory array has no reset; clearing it would need a
    // multi-cycle init sequence and would block RAM inference.
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_ahb3lite_sram_slave
//
// Three slave instances (WAIT_STATES 0, 3 and 2) share one clock. A directed
// sequence drives one instance at a time; each transfer pushes its expected
// response, read data and wait count onto a scoreboard queue, and a negedge
// monitor pops and compares when the data phase completes.
// -----------------------------------------------------------------------------
module tb_ahb3lite_sram_slave;

    localparam int N = 3;
    localparam int WS_TAB [N] = '{0, 3, 2};

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        hsel      [N];
    logic [31:0] haddr     [N];
    logic [31:0] hwdata    [N];
    logic [31:0] hrdata    [N];
    logic        hwrite    [N];
    logic [2:0]  hsize     [N];
    logic [1:0]  htrans    [N];
    logic        hready    [N];
    logic        hreadyout [N];
    logic        hresp     [N];
    logic        stall     [N];

    logic [31:0] mdl     [N][256];
    logic [31:0] last_rd [N];
    exp_t        sb [$];
    exp_t        mon_e;
    int          cur       = 0;
    int          waits     = 0;
    int          dp_cycles = 0;
    int          checks    = 0;
    int          errors    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign hready[g] = hreadyout[g] & ~stall[g];

        ahb3lite_sram_slave #(
            .HADDR_SIZE  (32),
            .HDATA_SIZE  (32),
            .MEM_DEPTH   (256),
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .HCLK      (clk),
            .HRESET    (rst[g]),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HWDATA    (hwdata[g]),
            .HRDATA    (hrdata[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (3'b000),
            .HPROT     (4'b0011),
            .HTRANS    (htrans[g]),
            .HMASTLOCK (1'b0),
            .HREADY    (hready[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (hready[k] !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 64) check("ready_timeout", 32'(n), 32'd0);
    endtask

    // One address phase; returns one cycle later, inside the data phase,
    // with HWDATA driven so the next call can pipeline behind it.
    task automatic xfer(input int k, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd);
        exp_t       e;
        int         off;
        int         nb;
        logic [7:0] idx;
        hsel[k]   = 1'b1;
        htrans[k] = trans;
        haddr[k]  = addr;
        hwrite[k] = wr;
        hsize[k]  = size;
        wait_ready(k);
        @(posedge clk); #1;
        hsel[k]   = 1'b0;
        htrans[k] = T_IDLE;
        hwdata[k] = wd;
        e.err   = (addr >= 32'd1024) || (size > 3'd2) ||
                  ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
        e.waits = e.err ? 1 : WS_TAB[k];
        idx = addr[9:2];
        off = int'(addr[1:0]);
        nb  = 1 << size;
        if (!e.err && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (!e.err && !wr) last_rd[k] = mdl[k][idx];
        e.rdata = last_rd[k];
        sb.push_back(e);
    endtask

    task automatic idle_step(input int k, input logic [1:0] trans, input string tag);
        hsel[k]   = 1'b1;
        htrans[k] = trans;
        haddr[k]  = 32'h0000_0400;
        hwrite[k] = 1'b1;
        hsize[k]  = 3'd2;
        wait_ready(k);
        @(posedge clk); #1;
        hsel[k]   = 1'b0;
        htrans[k] = T_IDLE;
        check({tag, "_ready"}, 32'(hreadyout[k]), 32'd1);
        check({tag, "_resp"},  32'(hresp[k]),     32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 128) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Scoreboard monitor: every negedge with an open data phase is either a
    // wait cycle or the completing cycle of the transfer at the queue head.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            dp_cycles++;
            if (hreadyout[cur] !== 1'b1) begin
                waits++;
                check("wait_resp", 32'(hresp[cur]), 32'(sb[0].err));
            end else begin
                mon_e = sb.pop_front();
                check("resp",  32'(hresp[cur]), 32'(mon_e.err));
                check("rdata", hrdata[cur],     mon_e.rdata);
                check("waits", 32'(waits),      32'(mon_e.waits));
                waits = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        for (int k = 0; k < N; k++) begin
            rst[k]     = 1'b1;
            hsel[k]    = 1'b0;
            haddr[k]   = 32'd0;
            hwdata[k]  = 32'd0;
            hwrite[k]  = 1'b0;
            hsize[k]   = 3'd2;
            htrans[k]  = T_IDLE;
            stall[k]   = 1'b0;
            last_rd[k] = 32'd0;
        end

        // Reset values on every instance.
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin
            check("rst_readyout", 32'(hreadyout[k]), 32'd1);
            check("rst_resp",     32'(hresp[k]),     32'd0);
            check("rst_rdata",    hrdata[k],         32'd0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) rst[k] = 1'b0;

        // ---------------- WAIT_STATES = 0 ----------------
        cur = 0;
        xfer(0, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        drain();
        xfer(0, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0);
        drain();
        check("rd_deadbeef", hrdata[0], 32'hDEADBEEF);

        // Byte lanes, fully pipelined (the read forwards from the halfword).
        xfer(0, T_NONSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344);
        xfer(0, T_NONSEQ, 1'b1, 32'h21, 3'd0, 32'h0000AA00);
        xfer(0, T_NONSEQ, 1'b1, 32'h22, 3'd1, 32'h55660000);
        xfer(0, T_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0);
        drain();
        check("lanes", hrdata[0], 32'h5566AA44);

        // Pipelined read-after-write.
        xfer(0, T_NONSEQ, 1'b1, 32'h40, 3'd2, 32'h0000CAFE);
        xfer(0, T_NONSEQ, 1'b0, 32'h40, 3'd2, 32'h0);
        drain();
        check("raw", hrdata[0], 32'h0000CAFE);

        // IDLE / BUSY interleaved with transfers.
        xfer(0, T_NONSEQ, 1'b1, 32'h44, 3'd2, 32'h00000001);
        idle_step(0, T_BUSY, "busy");
        idle_step(0, T_IDLE, "idle");
        xfer(0, T_NONSEQ, 1'b0, 32'h44, 3'd2, 32'h0);
        drain();

        // Top-of-memory byte and error responses.
        xfer(0, T_NONSEQ, 1'b1, 32'h0,   3'd2, 32'h01020304);
        xfer(0, T_NONSEQ, 1'b1, 32'h3FC, 3'd2, 32'h01234567);
        xfer(0, T_NONSEQ, 1'b1, 32'h3FF, 3'd0, 32'h77000000);
        xfer(0, T_NONSEQ, 1'b0, 32'h3FC, 3'd2, 32'h0);
        drain();
        check("top_byte", hrdata[0], 32'h77234567);
        xfer(0, T_NONSEQ, 1'b0, 32'h400, 3'd2, 32'h0);
        xfer(0, T_NONSEQ, 1'b1, 32'h3,   3'd1, 32'hFFFF0000);
        xfer(0, T_NONSEQ, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF);
        xfer(0, T_NONSEQ, 1'b1, 32'h8,   3'd3, 32'hFFFFFFFF);
        xfer(0, T_NONSEQ, 1'b1, 32'h2,   3'd2, 32'hFFFFFFFF);
        drain();
        check("err_rdata_held", hrdata[0], 32'h77234567);
        xfer(0, T_NONSEQ, 1'b0, 32'h0, 3'd2, 32'h0);
        drain();
        check("err_no_write", hrdata[0], 32'h01020304);

        // ---------------- WAIT_STATES = 3 ----------------
        cur = 1;
        xfer(1, T_NONSEQ, 1'b1, 32'h100, 3'd2, 32'hA0A0A0A0);
        xfer(1, T_NONSEQ, 1'b1, 32'h104, 3'd2, 32'hB1B1B1B1);
        xfer(1, T_NONSEQ, 1'b1, 32'h108, 3'd2, 32'hC2C2C2C2);
        xfer(1, T_NONSEQ, 1'b1, 32'h10C, 3'd2, 32'hD3D3D3D3);
        drain();
        xfer(1, T_NONSEQ, 1'b0, 32'h104, 3'd2, 32'h0);
        drain();
        check("ws3_single", hrdata[1], 32'hB1B1B1B1);

        c0 = dp_cycles;
        xfer(1, T_NONSEQ, 1'b0, 32'h100, 3'd2, 32'h0);
        xfer(1, T_SEQ,    1'b0, 32'h104, 3'd2, 32'h0);
        xfer(1, T_SEQ,    1'b0, 32'h108, 3'd2, 32'h0);
        xfer(1, T_SEQ,    1'b0, 32'h10C, 3'd2, 32'h0);
        drain();
        check("burst_cycles", 32'(dp_cycles - c0), 32'd16);
        check("burst_last", hrdata[1], 32'hD3D3D3D3);

        // Address phase while another slave holds HREADY low is ignored.
        stall[1]  = 1'b1;
        hsel[1]   = 1'b1;
        htrans[1] = T_NONSEQ;
        haddr[1]  = 32'h100;
        hwrite[1] = 1'b1;
        hsize[1]  = 3'd2;
        @(posedge clk); #1;
        hsel[1]   = 1'b0;
        htrans[1] = T_IDLE;
        hwdata[1] = 32'hFFFFFFFF;
        stall[1]  = 1'b0;
        check("stall_ignored", 32'(hreadyout[1]), 32'd1);
        @(posedge clk); #1;
        xfer(1, T_NONSEQ, 1'b0, 32'h100, 3'd2, 32'h0);
        drain();
        check("stall_no_write", hrdata[1], 32'hA0A0A0A0);

        // ---------------- WAIT_STATES = 2, reset mid-write ----------------
        cur = 2;
        xfer(2, T_NONSEQ, 1'b1, 32'h50, 3'd2, 32'h12345678);
        xfer(2, T_NONSEQ, 1'b0, 32'h50, 3'd2, 32'h0);
        drain();
        check("ws2_read", hrdata[2], 32'h12345678);
        hsel[2]   = 1'b1;
        htrans[2] = T_NONSEQ;
        haddr[2]  = 32'h50;
        hwrite[2] = 1'b1;
        hsize[2]  = 3'd2;
        wait_ready(2);
        @(posedge clk); #1;
        hsel[2]   = 1'b0;
        htrans[2] = T_IDLE;
        hwdata[2] = 32'h0BADF00D;
        check("mid_write_wait", 32'(hreadyout[2]), 32'd0);
        rst[2] = 1'b1;
        #1;
        check("mid_rst_readyout", 32'(hreadyout[2]), 32'd1);
        check("mid_rst_resp",     32'(hresp[2]),     32'd0);
        check("mid_rst_rdata",    hrdata[2],         32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[2]     = 1'b0;
        last_rd[2] = 32'd0;
        @(posedge clk); #1;
        xfer(2, T_NONSEQ, 1'b0, 32'h50, 3'd2, 32'h0);
        drain();
        check("mid_rst_no_commit", hrdata[2], 32'h12345678);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
